// File: rtl/norz_alu_op_sequencer.sv
// norz_alu_op_sequencer
//
// Self-timed sequencer for the 8-bit ALU-with-operand group
// (ADD/ADC/SUB/SBC/AND/XOR/OR/CP, immediate or (IX/IY+d) operand).
// It walks its own step counter and emits the step code together with
// the per-step datapath strobes.
//
// Optional feature macro: NORZ_ALU_SEQ_WAIT_EN
//   defined   : RA0/RA1 wait on mem_ready, with a timeout that pulses err
//   undefined : RA0/RA1 last one cycle each, mem_ready ignored, err = 0
//
// Parameters
//   XPT_W  width of the step-code output (>= 4)
//   TMO_W  width of the wait-timeout counter; limit is 2^TMO_W - 1 cycles
//
// Ports
//   clk, reset                  clock, async active-high reset
//   start, op, indexed, sel_iy  request and operand selection (latched in IDLE)
//   mem_ready                   operand read data valid
//   xpt, busy                   step code (0/3/8/9/10) and not-idle flag
//   sel_ix_high, sel_iy_high    index register select during DISP
//   sel_op_low, write_dt,
//   write_dtex, alu_add_disp    displacement strobes during DISP
//   ra                          one-hot read strobes: RA0, RA1, EXEC
//   alu_op, fclass              one-hot ALU function / flag class in EXEC
//   flag_write, write_a,
//   reset_xpt_itable, done      EXEC strobes
//   err                         one-cycle pulse after a wait timeout
//
// State table
//   state  | meaning
//   S_IDLE | waiting for start (xpt 0)
//   S_DISP | displacement add for indexed operand (xpt 3)
//   S_RA0  | first operand read cycle, indexed only (xpt 8)
//   S_RA1  | operand read (xpt 9)
//   S_EXEC | ALU execute, flags and A written (xpt 10)

module norz_alu_op_sequencer #(
  parameter int XPT_W = 4,
  parameter int TMO_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             indexed,
  input  logic             sel_iy,
  input  logic             mem_ready,
  output logic [XPT_W-1:0] xpt,
  output logic             busy,
  output logic             sel_ix_high,
  output logic             sel_iy_high,
  output logic             sel_op_low,
  output logic             write_dt,
  output logic             write_dtex,
  output logic [2:0]       ra,
  output logic [7:0]       alu_op,
  output logic             alu_add_disp,
  output logic             flag_write,
  output logic [3:0]       fclass,
  output logic             write_a,
  output logic             reset_xpt_itable,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISP,
    S_RA0,
    S_RA1,
    S_EXEC
  } state_t;

  localparam logic [2:0] OP_CP = 3'b111;

  localparam logic [XPT_W-1:0] XPT_IDLE = XPT_W'(0);
  localparam logic [XPT_W-1:0] XPT_DISP = XPT_W'(3);
  localparam logic [XPT_W-1:0] XPT_RA0  = XPT_W'(8);
  localparam logic [XPT_W-1:0] XPT_RA1  = XPT_W'(9);
  localparam logic [XPT_W-1:0] XPT_EXEC = XPT_W'(10);

  state_t     state, state_nxt;
  logic [2:0] op_q, op_nxt;
  logic       iy_q, iy_nxt;
  logic       err_nxt;

`ifdef NORZ_ALU_SEQ_WAIT_EN
  // Down-counter loaded with limit-1 on entry to a read step; reaching zero
  // while still waiting marks the limit-th wait cycle.
  localparam int unsigned TMO_LIM = (1 << TMO_W) - 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_LIM - 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  function automatic logic [7:0] alu_onehot(input logic [2:0] o);
    if (o == OP_CP) return 8'b0000_0100;  // CP is a SUB without the A write
    return 8'b0000_0001 << o;
  endfunction

  function automatic logic [3:0] fclass_of(input logic [2:0] o);
    case (o)
      3'b000, 3'b001:         return 4'b0001;
      3'b010, 3'b011, 3'b111: return 4'b0010;
      3'b100:                 return 4'b0100;
      default:                return 4'b1000;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    iy_nxt    = iy_q;
    err_nxt   = 1'b0;
`ifdef NORZ_ALU_SEQ_WAIT_EN
    tmo_nxt   = tmo_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          op_nxt    = op;
          iy_nxt    = sel_iy;
          state_nxt = indexed ? S_DISP : S_RA1;
`ifdef NORZ_ALU_SEQ_WAIT_EN
          tmo_nxt   = TMO_LOAD;
`endif
        end
      end
      S_DISP: begin
        state_nxt = S_RA0;
`ifdef NORZ_ALU_SEQ_WAIT_EN
        tmo_nxt   = TMO_LOAD;
`endif
      end
      S_RA0: begin
`ifdef NORZ_ALU_SEQ_WAIT_EN
        // mem_ready takes priority over an expiring timeout
        if (mem_ready) begin
          state_nxt = S_RA1;
          tmo_nxt   = TMO_LOAD;
        end else if (tmo_cnt == '0) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt   = tmo_cnt - 1'b1;
        end
`else
        state_nxt = S_RA1;
`endif
      end
      S_RA1: begin
`ifdef NORZ_ALU_SEQ_WAIT_EN
        if (mem_ready) begin
          state_nxt = S_EXEC;
        end else if (tmo_cnt == '0) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt   = tmo_cnt - 1'b1;
        end
`else
        state_nxt = S_EXEC;
`endif
      end
      S_EXEC:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state and next latched op, so they
  // line up with the state register and carry no path from the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      op_q             <= 3'b000;
      iy_q             <= 1'b0;
`ifdef NORZ_ALU_SEQ_WAIT_EN
      tmo_cnt          <= '0;
`endif
      xpt              <= XPT_IDLE;
      busy             <= 1'b0;
      sel_ix_high      <= 1'b0;
      sel_iy_high      <= 1'b0;
      sel_op_low       <= 1'b0;
      write_dt         <= 1'b0;
      write_dtex       <= 1'b0;
      alu_add_disp     <= 1'b0;
      ra               <= 3'b000;
      alu_op           <= 8'h00;
      flag_write       <= 1'b0;
      fclass           <= 4'b0000;
      write_a          <= 1'b0;
      reset_xpt_itable <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= state_nxt;
      op_q             <= op_nxt;
      iy_q             <= iy_nxt;
`ifdef NORZ_ALU_SEQ_WAIT_EN
      tmo_cnt          <= tmo_nxt;
`endif
      case (state_nxt)
        S_DISP:  xpt <= XPT_DISP;
        S_RA0:   xpt <= XPT_RA0;
        S_RA1:   xpt <= XPT_RA1;
        S_EXEC:  xpt <= XPT_EXEC;
        default: xpt <= XPT_IDLE;
      endcase
      busy             <= (state_nxt != S_IDLE);
      sel_ix_high      <= (state_nxt == S_DISP) && !iy_nxt;
      sel_iy_high      <= (state_nxt == S_DISP) && iy_nxt;
      sel_op_low       <= (state_nxt == S_DISP);
      write_dt         <= (state_nxt == S_DISP);
      write_dtex       <= (state_nxt == S_DISP);
      alu_add_disp     <= (state_nxt == S_DISP);
      ra               <= {state_nxt == S_EXEC, state_nxt == S_RA1, state_nxt == S_RA0};
      alu_op           <= (state_nxt == S_EXEC) ? alu_onehot(op_nxt) : 8'h00;
      flag_write       <= (state_nxt == S_EXEC);
      fclass           <= (state_nxt == S_EXEC) ? fclass_of(op_nxt) : 4'b0000;
      write_a          <= (state_nxt == S_EXEC) && (op_nxt != OP_CP);
      reset_xpt_itable <= (state_nxt == S_EXEC);
      done             <= (state_nxt == S_EXEC);
      err              <= err_nxt;
    end
  end

endmodule

// File: tb/tb_norz_alu_op_sequencer.sv
// Randomized scoreboard bench for norz_alu_op_sequencer. The driver expands
// each request into its expected per-cycle output records from the path and
// wait rules; a negedge monitor compares every busy/err cycle against them.

module tb_norz_alu_op_sequencer;

  localparam int XPT_W = 5;
  localparam int TMO_W = 2;
  localparam int LIM   = (1 << TMO_W) - 1;
`ifdef NORZ_ALU_SEQ_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] xpt;
    logic       busy;
    logic       six;
    logic       siy;
    logic       sol;
    logic       wdt;
    logic       wdtex;
    logic [2:0] ra;
    logic [7:0] alu_op;
    logic       add_disp;
    logic       fw;
    logic [3:0] fclass;
    logic       wa;
    logic       rst_it;
    logic       done;
    logic       err;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] op = 3'b000;
  logic indexed = 1'b0;
  logic sel_iy = 1'b0;
  logic mem_ready = 1'b0;
  logic [XPT_W-1:0] xpt;
  logic busy, sel_ix_high, sel_iy_high, sel_op_low, write_dt, write_dtex;
  logic [2:0] ra;
  logic [7:0] alu_op;
  logic alu_add_disp, flag_write;
  logic [3:0] fclass;
  logic write_a, reset_xpt_itable, done, err;

  norz_alu_op_sequencer #(.XPT_W(XPT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .indexed(indexed),
    .sel_iy(sel_iy), .mem_ready(mem_ready), .xpt(xpt), .busy(busy),
    .sel_ix_high(sel_ix_high), .sel_iy_high(sel_iy_high),
    .sel_op_low(sel_op_low), .write_dt(write_dt), .write_dtex(write_dtex),
    .ra(ra), .alu_op(alu_op), .alu_add_disp(alu_add_disp),
    .flag_write(flag_write), .fclass(fclass), .write_a(write_a),
    .reset_xpt_itable(reset_xpt_itable), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  rec_t act;
  assign act = {xpt, busy, sel_ix_high, sel_iy_high, sel_op_low, write_dt,
                write_dtex, ra, alu_op, alu_add_disp, flag_write, fclass,
                write_a, reset_xpt_itable, done, err};

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  rec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Expected outputs for one step, straight from the step/op tables.
  function automatic rec_t mk(input int step, input logic [2:0] o, input bit iy);
    rec_t r;
    r = '0;
    r.xpt  = 5'(step);
    r.busy = (step != 0);
    case (step)
      3: begin
        r.six = !iy; r.siy = iy; r.sol = 1'b1; r.wdt = 1'b1;
        r.wdtex = 1'b1; r.add_disp = 1'b1;
      end
      8: r.ra = 3'b001;
      9: r.ra = 3'b010;
      10: begin
        r.ra = 3'b100;
        r.alu_op = (o == 3'd7) ? 8'h04 : (8'h01 << o);
        r.fw = 1'b1;
        if (o <= 3'd1)                        r.fclass = 4'b0001;
        else if (o <= 3'd3 || o == 3'd7)      r.fclass = 4'b0010;
        else if (o == 3'd4)                   r.fclass = 4'b0100;
        else                                  r.fclass = 4'b1000;
        r.wa = (o != 3'd7);
        r.rst_it = 1'b1;
        r.done = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", act, 32'h0);
        end else begin
          chk("step_outputs", act, exp_q.pop_front());
        end
      end else begin
        chk("idle_outputs", act, 32'h0);
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; returns in the first idle
  // cycle after the op (or after the timeout).
  task automatic run_op(input logic [2:0] o, input bit idx, input bit iy,
                        input int w0, input int w1, input bit junk_xor);
    bit mrs[$];
    bit tmo;
    int nra;
    tmo = 1'b0;
    if (idx) begin
      exp_q.push_back(mk(3, o, iy));
      mrs.push_back(1'($urandom));
      if (WAIT_EN && w0 >= LIM) begin
        for (int i = 0; i < LIM; i++) begin
          exp_q.push_back(mk(8, o, iy)); mrs.push_back(1'b0);
        end
        tmo = 1'b1;
      end else begin
        nra = WAIT_EN ? w0 : 0;
        for (int i = 0; i < nra; i++) begin
          exp_q.push_back(mk(8, o, iy)); mrs.push_back(1'b0);
        end
        exp_q.push_back(mk(8, o, iy));
        mrs.push_back(WAIT_EN ? 1'b1 : 1'($urandom));
      end
    end
    if (!tmo) begin
      if (WAIT_EN && w1 >= LIM) begin
        for (int i = 0; i < LIM; i++) begin
          exp_q.push_back(mk(9, o, iy)); mrs.push_back(1'b0);
        end
        tmo = 1'b1;
      end else begin
        nra = WAIT_EN ? w1 : 0;
        for (int i = 0; i < nra; i++) begin
          exp_q.push_back(mk(9, o, iy)); mrs.push_back(1'b0);
        end
        exp_q.push_back(mk(9, o, iy));
        mrs.push_back(WAIT_EN ? 1'b1 : 1'($urandom));
      end
    end
    if (!tmo) begin
      exp_q.push_back(mk(10, o, iy));
      mrs.push_back(1'($urandom));
    end else begin
      rec_t e;
      e = mk(0, o, iy);
      e.err = 1'b1;
      exp_q.push_back(e);
    end

    start = 1'b1; op = o; indexed = idx; sel_iy = iy; mem_ready = 1'($urandom);
    foreach (mrs[i]) begin
      @(posedge clk); #1;
      // start while busy must be ignored
      start     = junk_xor ? 1'b1 : 1'($urandom);
      op        = junk_xor ? 3'b101 : 3'($urandom);
      indexed   = 1'($urandom);
      sel_iy    = 1'($urandom);
      mem_ready = mrs[i];
    end
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0; mem_ready = 1'($urandom);
    end
  endtask

  initial begin
    // reset state and reset during RA0
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", act, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1; op = 3'd0; indexed = 1'b1; sel_iy = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_disp_xpt", 32'(xpt), 32'd3);
    @(posedge clk); #1;
    chk("pre_reset_ra0", {24'h0, 3'(ra), xpt}, {24'h0, 3'b001, 5'd8});
    reset = 1'b1;
    #1;
    chk("reset_mid_op", act, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", act, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // directed cases
    run_op(3'd0, 1'b1, 1'b1, 0, 0, 1'b0);       // indexed ADD on IY
    run_op(3'd7, 1'b0, 1'b0, 0, 2, 1'b0);       // immediate CP, 2 waits
    idle(1);
    run_op(3'd2, 1'b1, 1'b0, LIM, 0, 1'b0);     // timeout in RA0
    run_op(3'd1, 1'b1, 1'b0, 1, 1, 1'b1);       // ADC with XOR start while busy
    run_op(3'd4, 1'b0, 1'b0, 0, LIM + 1, 1'b0); // timeout in RA1
    run_op(3'd6, 1'b1, 1'b1, LIM - 1, LIM - 1, 1'b0); // ready on limit cycle
    idle(2);

    // random ops
    for (int n = 0; n < 80; n++) begin
      run_op(3'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, LIM + 1)), int'($urandom_range(0, LIM + 1)),
             1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/norz_alu_op_sequencer.md
# norz_alu_op_sequencer

Self-timed sequencer for the 8-bit ALU-with-operand instruction group: ADD/ADC/SUB/SBC/AND/XOR/OR/CP against an immediate byte or an (IX+d)/(IY+d) memory operand. It owns its own step counter, so the top level does not have to drive the step code. It emits the same step codes (3, 8, 9, 10) and per-step control strobes as the combinational group decoder, and adds three things that decoder lacks:

- memory-ready handshake on the operand-read steps;
- wait timeout with error reporting;
- a parametrised step-code width.

It sits between the instruction-table latch and the register/ALU/flag datapath.

## Interface

Parameters:
- XPT_W, default 4: width of the step-code output; must be ≥ 4.
- TMO_W, default 4: width of the wait-timeout counter; timeout limit is 2^TMO_W − 1 cycles.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to 0.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  3  ALU op code: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 XOR, 110 OR, 111 CP.
- indexed  in  1  1 = (IX/IY+d) operand, 0 = immediate operand.
- sel_iy  in  1  with indexed=1: 0 = IX, 1 = IY.
- mem_ready  in  1  memory read data valid this cycle.
- xpt  out  XPT_W  current step code: 0 IDLE, 3 DISP, 8 RA0, 9 RA1, 10 EXEC; zero-extended.
- busy  out  1  high in every state except IDLE.
- sel_ix_high, sel_iy_high  out  1  high during DISP for the selected index register.
- sel_op_low, write_dt, write_dtex  out  1  high during DISP.
- ra  out  3  one-hot read-address strobes: bit0 in RA0, bit1 in RA1, bit2 in EXEC.
- alu_op  out  8  one-hot ALU function, valid in EXEC. Bit order: ADD, ADC, SUB, SBC, AND, XOR, OR. CP drives the SUB bit; bit7 is reserved and always 0.
- alu_add_disp  out  1  ADD select during DISP, for the displacement add.
- flag_write  out  1  all six flag write enables, high in EXEC.
- fclass  out  4  one-hot flag-source class in EXEC: [0] ADD/ADC, [1] SUB/SBC/CP, [2] AND, [3] OR/XOR.
- write_a  out  1  high in EXEC unless op = CP.
- reset_xpt_itable  out  1  high in EXEC; clears the upstream latches.
- done  out  1  one-cycle pulse in EXEC.
- err  out  1  one-cycle pulse when a wait times out.

## Operation

- States and step codes: IDLE (0), DISP (3), RA0 (8), RA1 (9), EXEC (10).
- Latching: in IDLE, start=1 latches op, indexed and sel_iy. These latched values drive all later outputs; the inputs are don't-care after the start cycle.
- Indexed path: IDLE → DISP → RA0 → RA1 → EXEC → IDLE.
- Immediate path: IDLE → RA1 → EXEC → IDLE.
- DISP lasts exactly 1 cycle.
- RA0 and RA1 each hold until mem_ready=1 (see Configuration), then advance on that edge.
- EXEC lasts exactly 1 cycle. Then the machine returns to IDLE; the op is retired.
- Timeout counter: cleared on entry to RA0 or RA1; increments each cycle mem_ready=0. When it reaches 2^TMO_W − 1 with mem_ready still 0:
  - err pulses;
  - the machine returns to IDLE next cycle;
  - no EXEC outputs are issued.
- start while busy is ignored; no queueing.
- mem_ready outside RA0/RA1 is ignored.
- All outputs are registered-state decodes: a function of the current state and latched op only, with no combinational path from inputs.

## Timing

- Reset: every output is 0, xpt = 0, state = IDLE. Asserting reset mid-op aborts immediately, with no done and no err.
- Indexed op, zero waits: start at cycle 0 → DISP at 1, RA0 at 2, RA1 at 3, EXEC at 4 (done=1), IDLE at 5.
- Immediate op, zero waits: start at 0 → RA1 at 1, EXEC at 2.
- Each cycle of mem_ready=0 in RA0/RA1 adds one cycle of latency.
- Simultaneous mem_ready=1 and timeout-limit cycle: mem_ready wins; the machine advances, no err.
- A new start is accepted in the IDLE cycle after EXEC, giving back-to-back ops with one idle cycle.

## Configuration

- NORZ_ALU_SEQ_WAIT_EN defined: mem_ready handshake and timeout are active, as described above.
- NORZ_ALU_SEQ_WAIT_EN undefined:
  - RA0 and RA1 each last exactly 1 cycle;
  - mem_ready is ignored;
  - the timeout counter is removed;
  - err is tied to 0.

## Test plan

- Reset during RA0 of an indexed op → next cycle: xpt=0, busy=0, all strobes 0, no done or err.
- Indexed ADD on IY, mem_ready always 1 → xpt sequence 3, 8, 9, 10, 0.
  - sel_iy_high=1 in DISP.
  - EXEC: alu_op=0000_0001, fclass=0001, write_a=1, done=1.
- Immediate CP, mem_ready low for 2 cycles in RA1 → RA1 held 3 cycles; EXEC with alu_op=0000_0100, fclass=0010, write_a=0.
- TMO_W=2, mem_ready held 0 in RA0 → err pulses after 3 wait cycles, return to IDLE, no done.
- start re-asserted while busy with op=XOR → ignored; the in-flight ADC completes with alu_op=0000_0010.
- Macro undefined, mem_ready=0 throughout → indexed op completes in 5 cycles, err never asserted.
